// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with big-endian load extraction and LL/SC link bit (optional: WB_LLBIT_EN)
module mem_wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_mem,
  input  logic          stall_wb,
  input  logic          flush,
  input  logic [AW-1:0] mem_wd,
  input  logic          mem_wreg,
  input  logic [DW-1:0] mem_wdata,
  input  logic [2:0]    mem_ldtype,
  input  logic [1:0]    mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] mem_reg2,
  input  logic          mem_llbit_we,
  input  logic          mem_llbit_value,
  output logic [AW-1:0] wb_wd,
  output logic          wb_wreg,
  output logic [DW-1:0] wb_wdata,
  output logic          llbit_o
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  logic [AW-1:0] wd_q;
  logic          wreg_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    ldtype_q;
  logic [1:0]    addr_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] reg2_q;

  // Capture MEM results; flush and MEM stall both turn into a bubble, WB stall holds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      wdata_q  <= '0;
      ldtype_q <= LD_NONE;
      addr_q   <= 2'b00;
      rdata_q  <= '0;
      reg2_q   <= '0;
    end else if (stall_wb) begin
      wd_q     <= wd_q;
      wreg_q   <= wreg_q;
      wdata_q  <= wdata_q;
      ldtype_q <= ldtype_q;
      addr_q   <= addr_q;
      rdata_q  <= rdata_q;
      reg2_q   <= reg2_q;
    end else if (stall_mem) begin
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      wdata_q  <= '0;
      ldtype_q <= LD_NONE;
      addr_q   <= 2'b00;
      rdata_q  <= '0;
      reg2_q   <= '0;
    end else begin
      wd_q     <= mem_wd;
      wreg_q   <= mem_wreg;
      wdata_q  <= mem_wdata;
      ldtype_q <= mem_ldtype;
      addr_q   <= mem_addr;
      rdata_q  <= mem_rdata;
      reg2_q   <= mem_reg2;
    end
  end

  assign wb_wd   = wd_q;
  assign wb_wreg = wreg_q;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Big-endian extraction: address 0 names the most significant byte of the bus word.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    wb_wdata = wdata_q;
    case (addr_q)
      2'd0:    byte_sel = rdata_q[DW-1 -: 8];
      2'd1:    byte_sel = rdata_q[DW-9 -: 8];
      2'd2:    byte_sel = rdata_q[15:8];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = addr_q[1] ? rdata_q[15:0] : rdata_q[DW-1 -: 16];
    case (ldtype_q)
      LD_LB:   wb_wdata = {{(DW-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  wb_wdata = {{(DW-8){1'b0}}, byte_sel};
      LD_LH:   wb_wdata = {{(DW-16){half_sel[15]}}, half_sel};
      LD_LHU:  wb_wdata = {{(DW-16){1'b0}}, half_sel};
      LD_LW:   wb_wdata = rdata_q;
      LD_LWL: begin
        case (addr_q)
          2'd0:    wb_wdata = rdata_q;
          2'd1:    wb_wdata = {rdata_q[DW-9:0],  reg2_q[7:0]};
          2'd2:    wb_wdata = {rdata_q[DW-17:0], reg2_q[15:0]};
          default: wb_wdata = {rdata_q[DW-25:0], reg2_q[23:0]};
        endcase
      end
      LD_LWR: begin
        case (addr_q)
          2'd0:    wb_wdata = {reg2_q[DW-1:8],  rdata_q[DW-1 -: 8]};
          2'd1:    wb_wdata = {reg2_q[DW-1:16], rdata_q[DW-1 -: 16]};
          2'd2:    wb_wdata = {reg2_q[DW-1:24], rdata_q[DW-1 -: 24]};
          default: wb_wdata = rdata_q;
        endcase
      end
      default: wb_wdata = wdata_q;
    endcase
  end

`ifdef WB_LLBIT_EN
  logic llbit_q;

  // Link bit: cleared by flush, held by any stall, otherwise written by LL/SC.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      llbit_q <= 1'b0;
    end else if (stall_wb || stall_mem) begin
      llbit_q <= llbit_q;
    end else if (mem_llbit_we) begin
      llbit_q <= mem_llbit_value;
    end
  end

  // Forward an in-flight link update so a following SC sees it without waiting a cycle.
  always_comb begin
    llbit_o = llbit_q;
    if (rst || flush) begin
      llbit_o = 1'b0;
    end else if (mem_llbit_we) begin
      llbit_o = mem_llbit_value;
    end
  end
`else
  logic unused_llbit;
  assign unused_llbit = mem_llbit_we ^ mem_llbit_value;
  assign llbit_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem;
  logic        stall_wb;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ldtype;
  logic [1:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_reg2;
  logic        mem_llbit_we;
  logic        mem_llbit_value;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        llbit_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef WB_LLBIT_EN
  localparam bit LL_EN = 1'b1;
`else
  localparam bit LL_EN = 1'b0;
`endif

  mem_wb_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_ldtype(mem_ldtype),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_reg2(mem_reg2),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .llbit_o(llbit_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [2:0] ldtype, input logic [1:0] addr,
                       input logic [31:0] rdata, input logic [31:0] reg2);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata; mem_ldtype = ldtype;
    mem_addr = addr; mem_rdata = rdata; mem_reg2 = reg2;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; stall_wb = 1'b1; stall_mem = 1'b1;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    drive(5'd17, 1'b1, 32'hFFFF_FFFF, 3'd0, 2'd0, 32'h0, 32'h0);
    tick();
    tick();
    vectors++;
    if (wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'h0) begin
      $display("FAIL reset_outputs: got wreg=%b wd=%0d wdata=%h expected 0/0/0", wb_wreg, wb_wd, wb_wdata);
      miscompares++;
    end
    vectors++;
    if (llbit_o !== 1'b0) begin
      $display("FAIL reset_llbit: got %b expected 0", llbit_o);
      miscompares++;
    end
    rst = 1'b0; flush = 1'b0; stall_wb = 1'b0; stall_mem = 1'b0;
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    drive(5'd0, 1'b0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_alu_write();
    drive(5'd5, 1'b1, 32'h1234_5678, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0);
    tick();
    vectors++;
    if (wb_wreg !== 1'b1 || wb_wd !== 5'd5 || wb_wdata !== 32'h1234_5678) begin
      $display("FAIL alu_write: got wreg=%b wd=%0d wdata=%h expected 1/5/12345678", wb_wreg, wb_wd, wb_wdata);
      miscompares++;
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lt [16];
    logic [1:0]  ad [16];
    logic [31:0] rd [16];
    logic [31:0] ex [16];
    lt[0]  = 3'd1; ad[0]  = 2'd1; rd[0]  = 32'h80F17F02; ex[0]  = 32'hFFFFFFF1;
    lt[1]  = 3'd2; ad[1]  = 2'd1; rd[1]  = 32'h80F17F02; ex[1]  = 32'h000000F1;
    lt[2]  = 3'd1; ad[2]  = 2'd2; rd[2]  = 32'h80F17F02; ex[2]  = 32'h0000007F;
    lt[3]  = 3'd3; ad[3]  = 2'd0; rd[3]  = 32'h80F17F02; ex[3]  = 32'hFFFF80F1;
    lt[4]  = 3'd4; ad[4]  = 2'd2; rd[4]  = 32'h80F17F02; ex[4]  = 32'h00007F02;
    lt[5]  = 3'd1; ad[5]  = 2'd0; rd[5]  = 32'h80F17F02; ex[5]  = 32'hFFFFFF80;
    lt[6]  = 3'd2; ad[6]  = 2'd3; rd[6]  = 32'h80F17F02; ex[6]  = 32'h00000002;
    lt[7]  = 3'd3; ad[7]  = 2'd1; rd[7]  = 32'h80F17F02; ex[7]  = 32'hFFFF80F1;
    lt[8]  = 3'd5; ad[8]  = 2'd0; rd[8]  = 32'h80F17F02; ex[8]  = 32'h80F17F02;
    lt[9]  = 3'd6; ad[9]  = 2'd1; rd[9]  = 32'hAABBCCDD; ex[9]  = 32'hBBCCDD44;
    lt[10] = 3'd7; ad[10] = 2'd1; rd[10] = 32'hAABBCCDD; ex[10] = 32'h1122AABB;
    lt[11] = 3'd6; ad[11] = 2'd3; rd[11] = 32'hAABBCCDD; ex[11] = 32'hDD223344;
    lt[12] = 3'd7; ad[12] = 2'd3; rd[12] = 32'hAABBCCDD; ex[12] = 32'hAABBCCDD;
    lt[13] = 3'd6; ad[13] = 2'd2; rd[13] = 32'hAABBCCDD; ex[13] = 32'hCCDD3344;
    lt[14] = 3'd7; ad[14] = 2'd0; rd[14] = 32'hAABBCCDD; ex[14] = 32'h112233AA;
    lt[15] = 3'd7; ad[15] = 2'd2; rd[15] = 32'hAABBCCDD; ex[15] = 32'h11AABBCC;
    for (int i = 0; i < 16; i++) begin
      drive(5'd8, 1'b1, 32'h5A5A_5A5A, lt[i], ad[i], rd[i], 32'h11223344);
      tick();
      vectors++;
      if (wb_wdata !== ex[i] || wb_wd !== 5'd8 || wb_wreg !== 1'b1) begin
        $display("FAIL load_%0d (type=%0d a=%0d): got wdata=%h wd=%0d wreg=%b expected %h/8/1",
                 i, lt[i], ad[i], wb_wdata, wb_wd, wb_wreg, ex[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_stall_mem();
    stall_mem = 1'b1;
    drive(5'd7, 1'b1, 32'h0BAD_0BAD, 3'd0, 2'd0, 32'h0, 32'h0);
    tick();
    vectors++;
    if (wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'h0) begin
      $display("FAIL stall_mem_bubble: got wreg=%b wd=%0d wdata=%h expected 0/0/0", wb_wreg, wb_wd, wb_wdata);
      miscompares++;
    end
    stall_mem = 1'b0;
  endtask

  task automatic test_stall_wb();
    drive(5'd9, 1'b1, 32'hCAFE_F00D, 3'd0, 2'd0, 32'h0, 32'h0);
    tick();
    stall_wb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(5'(i + 20), 1'b0, 32'h1111_0000 + 32'(i), 3'd5, 2'd1, 32'h7777_7777, 32'h0);
      stall_mem = i[0];
      tick();
      vectors++;
      if (wb_wreg !== 1'b1 || wb_wd !== 5'd9 || wb_wdata !== 32'hCAFE_F00D) begin
        $display("FAIL stall_wb_hold_%0d: got wreg=%b wd=%0d wdata=%h expected 1/9/cafef00d",
                 i, wb_wreg, wb_wd, wb_wdata);
        miscompares++;
      end
    end
    stall_wb = 1'b0; stall_mem = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; stall_wb = 1'b1;
    drive(5'd3, 1'b1, 32'h3333_3333, 3'd5, 2'd0, 32'h4444_4444, 32'h0);
    tick();
    vectors++;
    if (wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'h0) begin
      $display("FAIL flush_bubble: got wreg=%b wd=%0d wdata=%h expected 0/0/0", wb_wreg, wb_wd, wb_wdata);
      miscompares++;
    end
    flush = 1'b0; stall_wb = 1'b0;
  endtask

  task automatic test_llbit();
    drive(5'd0, 1'b0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0);
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    #1;
    vectors++;
    if (llbit_o !== LL_EN) begin
      $display("FAIL ll_forward: got %b expected %b", llbit_o, LL_EN);
      miscompares++;
    end
    tick();
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    #1;
    vectors++;
    if (llbit_o !== LL_EN) begin
      $display("FAIL ll_register: got %b expected %b", llbit_o, LL_EN);
      miscompares++;
    end
    stall_mem = 1'b1; mem_llbit_we = 1'b1; mem_llbit_value = 1'b0;
    tick();
    stall_mem = 1'b0; mem_llbit_we = 1'b0;
    #1;
    vectors++;
    if (llbit_o !== LL_EN) begin
      $display("FAIL ll_stall_mem_hold: got %b expected %b", llbit_o, LL_EN);
      miscompares++;
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (llbit_o !== 1'b0) begin
      $display("FAIL ll_flush_forward: got %b expected 0", llbit_o);
      miscompares++;
    end
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (llbit_o !== 1'b0) begin
      $display("FAIL ll_flush_register: got %b expected 0", llbit_o);
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    drive(5'd0, 1'b0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0);
    test_reset();
    test_alu_write();
    test_loads();
    test_stall_mem();
    test_stall_wb();
    test_flush();
    test_llbit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
